// File: rtl/pe_send_sched.sv
// Round-robin send scheduler: grants one of NUM_PE requesters the network interface,
// runs the send-request/ack handshake with timeout, then paces the payload words.
module pe_send_sched #(
  parameter int NUM_PE      = 4,
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               local_id,
  input  logic [NUM_PE-1:0]        pe_req,
  input  logic [NUM_PE*8-1:0]      pe_dst,
  input  logic [NUM_PE*6-1:0]      pe_len,
  input  logic [NUM_PE*6-1:0]      pe_id,
  input  logic [NUM_PE*DATA_W-1:0] pe_data,
  input  logic [NUM_PE-1:0]        pe_data_valid,
  output logic [NUM_PE-1:0]        pe_grant,
  output logic [NUM_PE-1:0]        pe_data_ready,
  output logic [NUM_PE-1:0]        pe_done,
  output logic [NUM_PE-1:0]        pe_err,
  output logic                     o_comm_send_req,
  input  logic                     i_comm_send_ack,
  input  logic                     i_if_ready,
  output logic                     o_data_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [7:0]               o_src,
  output logic [7:0]               o_dst,
  output logic [5:0]               o_seq_len,
  output logic [5:0]               o_id,
  output logic                     busy
);
  localparam int OW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [NUM_PE-1:0] r_grant, w_grant_next;
  logic [OW-1:0]     r_owner, w_owner_next;
  logic [OW-1:0]     r_last, w_last_next;
  logic              r_req, w_req_next;
  logic              r_tout, w_tout_next;
  logic [5:0]        r_cnt, w_cnt_next;
  logic [7:0]        r_wait, w_wait_next;
  logic [7:0]        r_src, w_src_next;
  logic [7:0]        r_dst, w_dst_next;
  logic [5:0]        r_len, w_len_next;
  logic [5:0]        r_id, w_id_next;

  logic [7:0]        w_dst [NUM_PE];
  logic [5:0]        w_len [NUM_PE];
  logic [5:0]        w_id  [NUM_PE];
  logic [DATA_W-1:0] w_data[NUM_PE];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_unpack
      assign w_dst[gi]  = pe_dst[gi*8 +: 8];
      assign w_len[gi]  = pe_len[gi*6 +: 6];
      assign w_id[gi]   = pe_id[gi*6 +: 6];
      assign w_data[gi] = pe_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin search begins one past the previous owner and wraps.
  logic          w_found;
  logic [OW-1:0] w_pick;
  logic [OW:0]   w_idx;
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_PE; k++) begin
      w_idx = {1'b0, r_last} + (OW+1)'(k);
      if (w_idx >= (OW+1)'(NUM_PE))
        w_idx = w_idx - (OW+1)'(NUM_PE);
      if (!w_found && pe_req[w_idx[OW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[OW-1:0];
      end
    end
  end

  logic w_xfer;
  assign o_data_valid = (r_state == S_SEND) && pe_data_valid[r_owner] && (r_cnt != 6'd0);
  assign w_xfer       = o_data_valid && i_if_ready;

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    w_req_next   = r_req;
    w_tout_next  = r_tout;
    w_cnt_next   = r_cnt;
    w_wait_next  = r_wait;
    w_src_next   = r_src;
    w_dst_next   = r_dst;
    w_len_next   = r_len;
    w_id_next    = r_id;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_next = w_pick;
          w_grant_next = NUM_PE'(1) << w_pick;
          w_src_next   = local_id;
          w_dst_next   = w_dst[w_pick];
          w_len_next   = w_len[w_pick];
          w_id_next    = w_id[w_pick];
          w_tout_next  = 1'b0;
          w_wait_next  = '0;
          if (w_len[w_pick] != 6'd0) begin
            w_state_next = S_REQ;
            w_req_next   = 1'b1;
          end else begin
            w_state_next = S_DONE;
          end
        end
      end
      S_REQ: begin
        // An ack arriving on the final allowed cycle still wins over the timeout.
        if (i_comm_send_ack) begin
          w_req_next   = 1'b0;
          w_cnt_next   = r_len;
          w_state_next = S_SEND;
        end else if (r_wait == 8'(ACK_TIMEOUT - 1)) begin
          w_req_next   = 1'b0;
          w_tout_next  = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          w_cnt_next = r_cnt - 6'd1;
          if (r_cnt == 6'd1)
            w_state_next = S_DONE;
        end
      end
      default: begin
        w_grant_next = '0;
        w_last_next  = r_owner;
        w_wait_next  = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= OW'(NUM_PE - 1);
      r_req   <= 1'b0;
      r_tout  <= 1'b0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_owner <= w_owner_next;
      r_last  <= w_last_next;
      r_req   <= w_req_next;
      r_tout  <= w_tout_next;
      r_cnt   <= w_cnt_next;
      r_wait  <= w_wait_next;
      r_src   <= w_src_next;
      r_dst   <= w_dst_next;
      r_len   <= w_len_next;
      r_id    <= w_id_next;
    end
  end

  assign pe_grant        = r_grant;
  assign o_comm_send_req = r_req;
  assign o_src           = r_src;
  assign o_dst           = r_dst;
  assign o_seq_len       = r_len;
  assign o_id            = r_id;
  assign busy            = (r_state != S_IDLE);
  assign o_data          = (r_state == S_SEND) ? w_data[r_owner] : '0;
  assign pe_data_ready   = ((r_state == S_SEND) && i_if_ready) ? r_grant : '0;
  assign pe_done         = ((r_state == S_DONE) && !r_tout) ? r_grant : '0;
  assign pe_err          = ((r_state == S_DONE) && r_tout) ? r_grant : '0;

endmodule

// File: tb/tb_pe_send_sched.sv
// Bench for pe_send_sched: packet-level reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_pe_send_sched;
  localparam int NP  = 4;
  localparam int DW  = 32;
  localparam int ATO = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      local_id;
  logic [NP-1:0]   pe_req;
  logic [NP*8-1:0] pe_dst;
  logic [NP*6-1:0] pe_len;
  logic [NP*6-1:0] pe_id;
  logic [NP*DW-1:0] pe_data;
  logic [NP-1:0]   pe_data_valid;
  logic [NP-1:0]   pe_grant, pe_data_ready, pe_done, pe_err;
  logic            o_comm_send_req, i_comm_send_ack, i_if_ready, o_data_valid;
  logic [DW-1:0]   o_data;
  logic [7:0]      o_src, o_dst;
  logic [5:0]      o_seq_len, o_id;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pe_send_sched #(.NUM_PE(NP), .DATA_W(DW), .ACK_TIMEOUT(ATO)) dut (
    .clk(clk), .rst(rst), .local_id(local_id),
    .pe_req(pe_req), .pe_dst(pe_dst), .pe_len(pe_len), .pe_id(pe_id),
    .pe_data(pe_data), .pe_data_valid(pe_data_valid),
    .pe_grant(pe_grant), .pe_data_ready(pe_data_ready), .pe_done(pe_done), .pe_err(pe_err),
    .o_comm_send_req(o_comm_send_req), .i_comm_send_ack(i_comm_send_ack),
    .i_if_ready(i_if_ready), .o_data_valid(o_data_valid), .o_data(o_data),
    .o_src(o_src), .o_dst(o_dst), .o_seq_len(o_seq_len), .o_id(o_id), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic bitof(input logic [NP-1:0] v, input int i);
    logic [NP-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int rr_pick(input logic [NP-1:0] req, input int last);
    for (int k = 1; k <= NP; k++)
      if (bitof(req, (last + k) % NP)) return (last + k) % NP;
    return 0;
  endfunction

  task automatic set_pe(input int p, input logic [7:0] d, input logic [5:0] l, input logic [5:0] id);
    pe_dst[p*8 +: 8] = d;
    pe_len[p*6 +: 6] = l;
    pe_id[p*6 +: 6]  = id;
  endtask

  // ---------------- input drivers: payload, IF ready, ack responder ----------------
  int ack_mode = 1, ack_delay = 0, cur_delay = 0, req_age = 0;
  int rdy_mode = 0, vld_mode = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) pe_data[p*DW +: DW] = $urandom;
      case (rdy_mode)
        0:       i_if_ready = 1'b1;
        1:       i_if_ready = ~i_if_ready;
        default: i_if_ready = 1'($urandom_range(0, 1));
      endcase
      pe_data_valid = (vld_mode == 0) ? '1 : NP'($urandom);
      if (o_comm_send_req) begin
        req_age++;
        if (req_age == 1)
          cur_delay = (ack_mode == 2) ? int'($urandom_range(0, ATO + 4)) : ack_delay;
        i_comm_send_ack = (ack_mode != 0) && (req_age > cur_delay);
      end else begin
        req_age = 0;
        i_comm_send_ack = 1'b0;
      end
    end
  end

  // ---------------- event log used by the hand-computed expectations ----------------
  logic [NP-1:0] grant_log[$];
  logic [NP-1:0] prev_grant = '0, last_done = '0, last_err = '0;
  int req_cycles = 0, xfers = 0, done_cnt = 0, err_cnt = 0, rdy_hi = 0;
  logic [7:0] g_dst = '0;
  logic [5:0] g_len = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pe_grant != '0 && prev_grant == '0) begin
          grant_log.push_back(pe_grant);
          g_dst = o_dst;
          g_len = o_seq_len;
        end
        if (o_comm_send_req) req_cycles++;
        if (o_data_valid && i_if_ready) xfers++;
        rdy_hi += $countones(pe_data_ready);
        if (pe_done != '0) begin done_cnt++; last_done = pe_done; end
        if (pe_err != '0) begin err_cnt++; last_err = pe_err; end
      end
      prev_grant = pe_grant;
    end
  end

  task automatic clear_logs();
    grant_log.delete();
    req_cycles = 0; xfers = 0; done_cnt = 0; err_cnt = 0; rdy_hi = 0;
    last_done = '0; last_err = '0;
  endtask

  // ---------------- packet-level reference model, checked every cycle ----------------
  logic model_on = 1'b0;
  int m_last = NP - 1;
  logic [7:0] m_src, m_dst;
  logic [5:0] m_len, m_id;

  task automatic exp_cyc(input logic [NP-1:0] g, input logic b, input logic sreq, input logic dv,
                         input logic [DW-1:0] d, input logic [NP-1:0] rdy, input logic [NP-1:0] dn,
                         input logic [NP-1:0] er, input logic hdr);
    chk("grant", 64'(pe_grant), 64'(g));
    chk("busy", 64'(busy), 64'(b));
    chk("send_req", 64'(o_comm_send_req), 64'(sreq));
    chk("data_valid", 64'(o_data_valid), 64'(dv));
    chk("data", 64'(o_data), 64'(d));
    chk("data_ready", 64'(pe_data_ready), 64'(rdy));
    chk("done", 64'(pe_done), 64'(dn));
    chk("err", 64'(pe_err), 64'(er));
    if (hdr) begin
      chk("src", 64'(o_src), 64'(m_src));
      chk("dst", 64'(o_dst), 64'(m_dst));
      chk("seq_len", 64'(o_seq_len), 64'(m_len));
      chk("id", 64'(o_id), 64'(m_id));
    end
  endtask

  initial begin : model
    int win, left;
    logic acked;
    logic [NP-1:0] g;
    forever begin
      @(negedge clk);
      if (rst) begin m_last = NP - 1; continue; end
      if (!model_on) continue;
      exp_cyc('0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      if (pe_req == '0) continue;
      win   = rr_pick(pe_req, m_last);
      g     = NP'(1) << win;
      m_src = local_id;
      m_dst = pe_dst[win*8 +: 8];
      m_len = pe_len[win*6 +: 6];
      m_id  = pe_id[win*6 +: 6];
      if (m_len == 6'd0) begin
        @(negedge clk);
        exp_cyc(g, 1'b1, 1'b0, 1'b0, '0, '0, g, '0, 1'b1);
        m_last = win;
        continue;
      end
      acked = 1'b0;
      for (int w = 0; w < ATO && !acked; w++) begin
        @(negedge clk);
        exp_cyc(g, 1'b1, 1'b1, 1'b0, '0, '0, '0, '0, 1'b1);
        acked = i_comm_send_ack;
      end
      if (!acked) begin
        @(negedge clk);
        exp_cyc(g, 1'b1, 1'b0, 1'b0, '0, '0, '0, g, 1'b1);
        m_last = win;
        continue;
      end
      left = int'(m_len);
      while (left > 0) begin
        @(negedge clk);
        exp_cyc(g, 1'b1, 1'b0, bitof(pe_data_valid, win), pe_data[win*DW +: DW],
                i_if_ready ? g : '0, '0, '0, 1'b1);
        if (bitof(pe_data_valid, win) && i_if_ready) left--;
      end
      @(negedge clk);
      exp_cyc(g, 1'b1, 1'b0, 1'b0, '0, '0, g, '0, 1'b1);
      m_last = win;
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_grant(input string nm, input int budget);
    int c = 0;
    while (pe_grant == '0 && c < budget) begin @(posedge clk); #1; c++; end
    chk({nm, "_grant_seen"}, 64'(pe_grant != '0), 64'(1));
  endtask

  task automatic wait_ends(input string nm, input int n, input int budget);
    int c = 0;
    while ((done_cnt + err_cnt) < n && c < budget) begin @(posedge clk); #1; c++; end
    chk({nm, "_ends_reached"}, 64'((done_cnt + err_cnt) >= n), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  logic [NP-1:0] order_exp[5];
  initial begin
    rst = 1'b1; local_id = 8'hA7; pe_req = '0; pe_dst = '0; pe_len = '0; pe_id = '0;
    pe_data = '0; pe_data_valid = '1; i_comm_send_ack = 1'b0; i_if_ready = 1'b1;
    order_exp[0] = 4'b0001; order_exp[1] = 4'b0010; order_exp[2] = 4'b0100;
    order_exp[3] = 4'b1000; order_exp[4] = 4'b0001;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(pe_grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_send_req", 64'(o_comm_send_req), 64'(0));
    chk("rst_data_valid", 64'(o_data_valid), 64'(0));
    chk("rst_data", 64'(o_data), 64'(0));
    chk("rst_done_err_rdy", 64'({pe_done, pe_err, pe_data_ready}), 64'(0));
    chk("rst_hdr", 64'({o_src, o_dst, o_seq_len, o_id}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_on = 1'b1;

    // Round-robin rotation with all PEs requesting, one-word packets.
    clear_logs();
    for (int p = 0; p < NP; p++) set_pe(p, 8'(8'h10 + p), 6'd1, 6'(p));
    pe_req = 4'hF;
    wait_ends("t039", 5, 100);
    pe_req = '0;
    chk("t039_ngrants", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) chk($sformatf("t039_order%0d", i), 64'(grant_log[i]), 64'(order_exp[i]));

    // Single 3-word packet, ack after two cycles of request; header fields changed after grant.
    clear_logs();
    ack_delay = 2;
    set_pe(0, 8'h05, 6'd3, 6'h2A);
    pe_req = 4'b0001;
    wait_grant("t038", 50);
    pe_req = '0;
    set_pe(0, 8'hEE, 6'd9, 6'h11);
    wait_ends("t038", 1, 100);
    chk("t038_dst", 64'(g_dst), 64'(8'h05));
    chk("t038_seq_len", 64'(g_len), 64'(3));
    chk("t038_req_cycles", 64'(req_cycles), 64'(3));
    chk("t038_xfers", 64'(xfers), 64'(3));
    chk("t038_done_cnt", 64'(done_cnt), 64'(1));
    chk("t038_done_vec", 64'(last_done), 64'(4'b0001));

    // IF ready toggling during a 4-word packet.
    clear_logs();
    ack_delay = 1; rdy_mode = 1;
    set_pe(3, 8'h33, 6'd4, 6'h03);
    pe_req = 4'b1000;
    wait_grant("t040", 50);
    pe_req = '0;
    wait_ends("t040", 1, 100);
    rdy_mode = 0;
    chk("t040_xfers", 64'(xfers), 64'(4));
    chk("t040_ready_cycles", 64'(rdy_hi), 64'(4));
    chk("t040_done_vec", 64'(last_done), 64'(4'b1000));

    // Ack never arrives.
    clear_logs();
    ack_mode = 0;
    set_pe(1, 8'h21, 6'd2, 6'h01);
    pe_req = 4'b0010;
    wait_grant("t041", 50);
    pe_req = '0;
    wait_ends("t041", 1, ATO + 20);
    ack_mode = 1;
    chk("t041_req_cycles", 64'(req_cycles), 64'(ATO));
    chk("t041_err_cnt", 64'(err_cnt), 64'(1));
    chk("t041_err_vec", 64'(last_err), 64'(4'b0010));
    chk("t041_done_cnt", 64'(done_cnt), 64'(0));
    chk("t041_xfers", 64'(xfers), 64'(0));

    // Zero-length packet on PE2.
    clear_logs();
    set_pe(2, 8'h42, 6'd0, 6'h02);
    pe_req = 4'b0100;
    wait_grant("t042", 50);
    pe_req = '0;
    wait_ends("t042", 1, 50);
    chk("t042_req_cycles", 64'(req_cycles), 64'(0));
    chk("t042_done_vec", 64'(last_done), 64'(4'b0100));
    chk("t042_xfers", 64'(xfers), 64'(0));
    if (grant_log.size() > 0) chk("t042_grant", 64'(grant_log[0]), 64'(4'b0100));

    // Randomized traffic.
    ack_mode = 2; rdy_mode = 2; vld_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 7) == 0) pe_req = NP'($urandom);
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 3) == 0) set_pe(p, 8'($urandom), 6'($urandom_range(0, 5)), 6'($urandom));
      if ($urandom_range(0, 99) == 0) local_id = 8'($urandom);
    end
    pe_req = '0;
    for (int c = 0; c < 200 && busy; c++) begin @(posedge clk); #1; end
    chk("drain_idle", 64'(busy), 64'(0));

    // Reset in the middle of a 5-word packet.
    model_on = 1'b0;
    ack_mode = 1; ack_delay = 0; rdy_mode = 0; vld_mode = 0;
    clear_logs();
    set_pe(1, 8'h51, 6'd5, 6'h15);
    pe_req = 4'b0010;
    for (int c = 0; c < 50 && xfers < 2; c++) begin @(posedge clk); #1; end
    chk("t043_two_words", 64'(xfers >= 2), 64'(1));
    rst = 1'b1;
    pe_req = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t043_busy", 64'(busy), 64'(0));
    chk("t043_grant", 64'(pe_grant), 64'(0));
    chk("t043_send_req", 64'(o_comm_send_req), 64'(0));
    chk("t043_data", 64'({o_data_valid, o_data}), 64'(0));
    chk("t043_done_err_rdy", 64'({pe_done, pe_err, pe_data_ready}), 64'(0));
    chk("t043_hdr", 64'({o_src, o_dst, o_seq_len, o_id}), 64'(0));
    @(posedge clk); #1;
    chk("t043_next_grant", 64'(pe_grant), 64'(4'b0001));
    chk("t043_no_done_err", 64'(done_cnt + err_cnt), 64'(0));
    pe_req = '0;
    wait_ends("t043", 1, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
